// File: rtl/inverse_pkg.sv
// Shared types and width constants for the inverse datapath and its divider arbiter.
package inverse_pkg;

  localparam int DIV_NUM_REQ    = 4;
  localparam int DIV_DIVIDEND_W = 32;
  localparam int DIV_DIVISOR_W  = 32;
  localparam int DIV_QUOT_W     = 48;
  localparam int DIV_MAX_OUT    = 16;

  localparam int TAG_W = $clog2(DIV_NUM_REQ);
  localparam int CNT_W = $clog2(DIV_MAX_OUT) + 1;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_ISSUE = 1'b1
  } arb_state_e;

  // Tag width for an arbitrary lane count; never narrower than one bit.
  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inverse_tag_fifo.sv
// In-order requester-ID FIFO; head is visible combinationally so a pop can route in the same cycle.
module inverse_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    // Simultaneous push and pop leave the occupancy unchanged.
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/inverse_div_arbiter.sv
// Round-robin sharing of one AXI-Stream divider among NUM_REQ lanes, with in-order result routing.
// Optional per-lane grant and stall counters are built when DIV_ARB_STATS_EN is defined.
module inverse_div_arbiter
  import inverse_pkg::*;
#(
  parameter int NUM_REQ         = DIV_NUM_REQ,
  parameter int DIVIDEND_WIDTH  = DIV_DIVIDEND_W,
  parameter int DIVISOR_WIDTH   = DIV_DIVISOR_W,
  parameter int QUOT_WIDTH      = DIV_QUOT_W,
  parameter int MAX_OUTSTANDING = DIV_MAX_OUT
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0]   req_dividend,
  input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]    req_divisor,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [QUOT_WIDTH-1:0]               rsp_data,
  output logic [DIVIDEND_WIDTH-1:0]           m_axis_dividend_tdata,
  output logic                                m_axis_dividend_tvalid,
  input  logic                                m_axis_dividend_tready,
  output logic [DIVISOR_WIDTH-1:0]            m_axis_divisor_tdata,
  output logic                                m_axis_divisor_tvalid,
  input  logic                                m_axis_divisor_tready,
  input  logic [QUOT_WIDTH-1:0]               s_axis_dout_tdata,
  input  logic                                s_axis_dout_tvalid,
  output logic                                busy,
`ifdef DIV_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0]               grant_cnt,
  output logic [31:0]                         stall_cnt,
`endif
  output logic                                err_orphan
);
  localparam int TW = tag_width(NUM_REQ);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_e                state_q, state_d;
  logic [TW-1:0]             rr_ptr_q, rr_ptr_d;
  logic                      run_q;
  logic [DIVIDEND_WIDTH-1:0] dividend_q, dividend_d, dividend_sel;
  logic [DIVISOR_WIDTH-1:0]  divisor_q, divisor_d, divisor_sel;
  logic                      dvd_valid_q, dvd_valid_d;
  logic                      dvs_valid_q, dvs_valid_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [QUOT_WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic                      err_orphan_q, err_orphan_d;

  logic                      grant_found, grant;
  logic [TW-1:0]             grant_idx, sel;
  int                        idx;
  logic [TW-1:0]             fifo_head;
  logic [CW-1:0]             fifo_count;
  logic                      fifo_full, fifo_empty, fifo_pop;

  // First requesting lane at or above rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    sel         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = TW'(idx);
      if (!grant_found && req_valid[sel]) begin
        grant_found = 1'b1;
        grant_idx   = sel;
      end
    end
  end

  always_comb begin
    dividend_sel = '0;
    divisor_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == TW'(i)) begin
        dividend_sel = req_dividend[i*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
        divisor_sel  = req_divisor[i*DIVISOR_WIDTH +: DIVISOR_WIDTH];
      end
    end
  end

  // run_q keeps the combinational grant quiet while reset is asserted.
  assign grant     = run_q & (state_q == ARB_IDLE) & grant_found & ~fifo_full;
  assign req_ready = grant ? (NUM_REQ'(1) << grant_idx) : '0;
  assign fifo_pop  = s_axis_dout_tvalid & ~fifo_empty;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    dvd_valid_d  = dvd_valid_q;
    dvs_valid_d  = dvs_valid_q;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    err_orphan_d = err_orphan_q | (s_axis_dout_tvalid & fifo_empty);
    case (state_q)
      ARB_IDLE: begin
        if (grant) begin
          dividend_d  = dividend_sel;
          divisor_d   = divisor_sel;
          dvd_valid_d = 1'b1;
          dvs_valid_d = 1'b1;
          rr_ptr_d    = (grant_idx == TW'(NUM_REQ - 1)) ? '0 : grant_idx + TW'(1);
          state_d     = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        // The two channels complete independently; leave only when both are done.
        if (m_axis_dividend_tready) dvd_valid_d = 1'b0;
        if (m_axis_divisor_tready)  dvs_valid_d = 1'b0;
        if (!dvd_valid_d && !dvs_valid_d) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (fifo_pop) begin
      rsp_valid_d = NUM_REQ'(1) << fifo_head;
      rsp_data_d  = s_axis_dout_tdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      rr_ptr_q     <= '0;
      run_q        <= 1'b0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      dvd_valid_q  <= 1'b0;
      dvs_valid_q  <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      run_q        <= 1'b1;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      dvd_valid_q  <= dvd_valid_d;
      dvs_valid_q  <= dvs_valid_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  inverse_tag_fifo #(
    .WIDTH (TW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (grant),
    .push_data (grant_idx),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_axis_dividend_tdata  = dividend_q;
  assign m_axis_dividend_tvalid = dvd_valid_q;
  assign m_axis_divisor_tdata   = divisor_q;
  assign m_axis_divisor_tvalid  = dvs_valid_q;
  assign rsp_valid              = rsp_valid_q;
  assign rsp_data               = rsp_data_q;
  assign err_orphan             = err_orphan_q;
  assign busy                   = (state_q != ARB_IDLE) | (fifo_count != '0);

`ifdef DIV_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
    logic [15:0] cnt_q, cnt_d;
    assign cnt_d = (req_ready[gi] && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end
    assign grant_cnt[gi*16 +: 16] = cnt_q;
  end

  logic [31:0] stall_cnt_q, stall_cnt_d;
  assign stall_cnt_d = (|req_valid && fifo_full && stall_cnt_q != 32'hFFFF_FFFF) ?
                       stall_cnt_q + 32'd1 : stall_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inverse_div_arbiter.sv
// Randomized scoreboard bench for inverse_div_arbiter with a latency-programmable divider model.
module tb_inverse_div_arbiter;
  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int VW   = 32;
  localparam int QW   = 48;
  localparam int MAXO = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid, req_ready, rsp_valid;
  logic [N*DW-1:0]   req_dividend;
  logic [N*VW-1:0]   req_divisor;
  logic [QW-1:0]     rsp_data, dout_tdata;
  logic [DW-1:0]     dvd_tdata;
  logic [VW-1:0]     dvs_tdata;
  logic              dvd_tvalid, dvd_tready, dvs_tvalid, dvs_tready, dout_tvalid;
  logic              busy, err_orphan;
`ifdef DIV_ARB_STATS_EN
  logic [N*16-1:0]   grant_cnt;
  logic [31:0]       stall_cnt;
`endif

  initial forever #5 clk = ~clk;

  inverse_div_arbiter #(
    .NUM_REQ(N), .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW),
    .QUOT_WIDTH(QW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .m_axis_dividend_tdata(dvd_tdata), .m_axis_dividend_tvalid(dvd_tvalid),
    .m_axis_dividend_tready(dvd_tready),
    .m_axis_divisor_tdata(dvs_tdata), .m_axis_divisor_tvalid(dvs_tvalid),
    .m_axis_divisor_tready(dvs_tready),
    .s_axis_dout_tdata(dout_tdata), .s_axis_dout_tvalid(dout_tvalid),
    .busy(busy),
`ifdef DIV_ARB_STATS_EN
    .grant_cnt(grant_cnt), .stall_cnt(stall_cnt),
`endif
    .err_orphan(err_orphan)
  );

  typedef struct { logic [31:0] a; logic [31:0] b; } item_t;
  typedef struct { int lane; logic [QW-1:0] q; } exp_t;
  typedef struct { int due; logic [QW-1:0] d; } pend_t;

  item_t       lane_q[N][$];
  item_t       iss_q[$];
  exp_t        sb_q[$];
  pend_t       pend_q[$];
  logic [31:0] dvd_hq[$], dvs_hq[$];
  int          glog[$];

  int errors = 0, checks = 0, cyc = 0, lat = 8;
  int m_cnt = 0, mptr = 0, n_grants = 0, n_rsp = 0, n_coll = 0;
  bit pop_now = 0, orph_now = 0, prev_pop = 0, prev_orph = 0, inject = 0;
  logic [QW-1:0] last_data = '0;

  // Reference quotient: signed dividend/divisor in Q16 fraction; zero divisor yields a flag pattern.
  function automatic logic [QW-1:0] div_model(input logic [31:0] a, input logic [31:0] b);
    longint q;
    if (b == 32'd0) return {1'b1, 47'd0};
    q = (longint'($signed(a)) * 64'sd65536) / longint'($signed(b));
    return q[QW-1:0];
  endfunction

  task automatic fail_msg(input string name, input logic [127:0] act, input logic [127:0] req);
    errors++;
    $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) fail_msg(name, act, req);
  endtask

  initial forever @(posedge clk) cyc++;

  // Lane drivers, grant checker, divider model.
  logic [N-1:0] hs_v, exp_oh;
  int           exp_l;
  bit           found;
  item_t        it;
  logic [31:0]  pa, pb;
  pend_t        pe;
  initial begin
    req_valid = '0; req_dividend = '0; req_divisor = '0;
    dout_tvalid = 1'b0; dout_tdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        pop_now  = dout_tvalid && (m_cnt > 0);
        orph_now = dout_tvalid && (m_cnt == 0);
        if (m_cnt == MAXO) begin
          checks++;
          if (req_ready !== '0) fail_msg("full_no_grant", req_ready, 0);
        end
        hs_v = req_valid & req_ready;
        if (hs_v != '0) begin
          found = 0; exp_l = 0;
          for (int k = 0; k < N; k++)
            if (!found && req_valid[(mptr + k) % N]) begin found = 1; exp_l = (mptr + k) % N; end
          exp_oh = '0; exp_oh[exp_l] = 1'b1;
          checks++;
          if (hs_v !== exp_oh) fail_msg("grant_lane", hs_v, exp_oh);
          if (pop_now && m_cnt == 3) n_coll++;
          it = lane_q[exp_l].pop_front();
          iss_q.push_back(it);
          sb_q.push_back('{exp_l, div_model(it.a, it.b)});
          glog.push_back(exp_l);
          mptr = (exp_l + 1) % N;
          n_grants++;
          m_cnt++;
          $display("grant lane=%0d dividend=%0d divisor=%0d", exp_l, $signed(it.a), $signed(it.b));
        end
        if (pop_now) m_cnt--;
        if (dvd_tvalid && dvd_tready) dvd_hq.push_back(dvd_tdata);
        if (dvs_tvalid && dvs_tready) dvs_hq.push_back(dvs_tdata);
        while (dvd_hq.size() > 0 && dvs_hq.size() > 0) begin
          pa = dvd_hq.pop_front();
          pb = dvs_hq.pop_front();
          checks++;
          if (iss_q.size() == 0) fail_msg("issue_unexpected", {pa, pb}, 0);
          else begin
            it = iss_q.pop_front();
            if ({pa, pb} !== {it.a, it.b}) fail_msg("issue_data", {pa, pb}, {it.a, it.b});
          end
          pend_q.push_back('{cyc + lat, div_model(pa, pb)});
        end
      end else begin
        pop_now = 0; orph_now = 0;
      end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        req_valid[i] = (lane_q[i].size() > 0);
        req_dividend[i*DW +: DW] = (lane_q[i].size() > 0) ? lane_q[i][0].a : '0;
        req_divisor[i*VW +: VW]  = (lane_q[i].size() > 0) ? lane_q[i][0].b : '0;
      end
      if (inject) begin
        dout_tvalid = 1'b1; dout_tdata = 48'hDEAD_BEEF_0001; inject = 0;
      end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        pe = pend_q.pop_front();
        dout_tvalid = 1'b1; dout_tdata = pe.d;
      end else begin
        dout_tvalid = 1'b0;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT strobes a result.
  exp_t e;
  logic [N-1:0] e_oh;
  initial forever begin
    @(negedge clk); #2;
    if (prev_orph) check("orphan_sticky", err_orphan, 1);
    if (rsp_valid != '0 || prev_pop) begin
      checks++;
      if (!prev_pop) fail_msg("rsp_unexpected", rsp_valid, 0);
      else if (sb_q.size() == 0) fail_msg("rsp_no_expect", rsp_valid, 0);
      else begin
        e = sb_q.pop_front();
        e_oh = '0; e_oh[e.lane] = 1'b1;
        if (rsp_valid !== e_oh || rsp_data !== e.q)
          fail_msg("rsp_route_data", {rsp_valid, rsp_data}, {e_oh, e.q});
        $display("rsp lane=%0d data=%h", e.lane, rsp_data);
        n_rsp++;
        last_data = rsp_data;
      end
    end
    prev_pop  = pop_now;
    prev_orph = orph_now;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic bit lanes_pending();
    for (int i = 0; i < N; i++) if (lane_q[i].size() > 0) return 1;
    return 0;
  endfunction

  task automatic drain(input string name);
    int t = 0;
    while ((lanes_pending() || sb_q.size() != 0 || pend_q.size() != 0 || busy) && t < 3000) begin
      step(1); t++;
    end
    step(2);
    check(name, (t >= 3000), 0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctl"}, {req_ready, rsp_valid, dvd_tvalid, dvs_tvalid, busy, err_orphan}, 0);
    check({name, "_data"}, {rsp_data, dvd_tdata, dvs_tdata}, 0);
  endtask

  initial begin
    int g0, r0, ng, dvd_n, dvs_n, last_dvs, t;
    int gr[2];
    dvd_tready = 1'b1; dvs_tready = 1'b1;
    step(3);
    check_zero("reset");
    rst_n = 1'b1;
    step(2);

    // Round-robin from pointer 0 with every lane requesting.
    for (int i = 0; i < 2; i++)
      for (int l = 0; l < N; l++) lane_q[l].push_back('{32'(1000 * (l + 1) + i), 32'(l + 3)});
    drain("rr_drain");
    check("rr_order", {glog[0], glog[1], glog[2], glog[3], glog[4]}, {32'd0, 32'd1, 32'd2, 32'd3, 32'd0});

    // Single lane.
    r0 = n_rsp;
    lane_q[2].push_back('{32'd100, 32'd4});
    drain("single_drain");
    check("single_rsp_count", n_rsp - r0, 1);
    check("single_rsp_data", last_data, 48'h19_0000);
    check("single_busy", busy, 0);

    // Push/pop collision at occupancy 3.
    lat = 5;
    for (int i = 0; i < 3; i++)
      for (int l = 0; l < N; l++) lane_q[l].push_back('{$urandom, 32'($urandom_range(1, 500))});
    drain("coll_drain");
    check("collision_seen", (n_coll > 0), 1);

    // FIFO full with a slow divider.
    lat = 20;
    g0 = n_grants;
    for (int i = 0; i < 3; i++)
      for (int l = 0; l < N; l++) lane_q[l].push_back('{$urandom, 32'($urandom_range(1, 500))});
    step(16);
    check("full_grants", n_grants - g0, MAXO);
`ifdef DIV_ARB_STATS_EN
    check("stall_cnt_moves", (stall_cnt > 0), 1);
`endif
    drain("full_drain");

    // Divisor channel stalls for three cycles.
    lat = 8;
    dvs_tready = 1'b0;
    lane_q[1].push_back('{32'd77, 32'd7});
    lane_q[3].push_back('{32'hFFFF_FF00, 32'd0});
    ng = 0; dvd_n = 0; dvs_n = 0; last_dvs = 0; gr[0] = 0; gr[1] = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (req_ready != '0 && ng < 2) begin gr[ng] = k; ng++; end
      if (ng == 1 && dvd_tvalid) dvd_n++;
      if (ng == 1 && dvs_tvalid) begin
        dvs_n++; last_dvs = k;
        if (dvs_n == 4) dvs_tready = 1'b1;
      end
    end
    dvs_tready = 1'b1;
    check("skew_grants", ng, 2);
    check("skew_dvd_cycles", dvd_n, 1);
    check("skew_dvs_cycles", dvs_n, 4);
    check("skew_next_grant", gr[1] - last_dvs, 1);
    drain("skew_drain");

    // Random traffic, random backpressure, occasional zero divisors.
    lat = $urandom_range(3, 12);
    for (int k = 0; k < 400; k++) begin
      int l;
      l = $urandom_range(0, N - 1);
      if ($urandom_range(0, 2) == 0 && lane_q[l].size() < 3)
        lane_q[l].push_back('{$urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom});
      dvd_tready = ($urandom_range(0, 3) != 0);
      dvs_tready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    dvd_tready = 1'b1; dvs_tready = 1'b1;
    drain("rand_drain");

    // Orphan result with nothing outstanding.
    r0 = n_rsp;
    check("orphan_before", err_orphan, 0);
    inject = 1;
    step(4);
    check("orphan_flag", err_orphan, 1);
    check("orphan_no_rsp", n_rsp - r0, 0);

    // Reset while a request is held in ISSUE.
    dvd_tready = 1'b0; dvs_tready = 1'b0;
    for (int l = 0; l < N; l++) lane_q[l].push_back('{32'(l + 9), 32'(l + 2)});
    t = 0;
    while (!dvd_tvalid && t < 20) begin step(1); t++; end
    check("issue_reached", dvd_tvalid, 1);
    rst_n = 1'b0;
    for (int l = 0; l < N; l++) lane_q[l].delete();
    iss_q.delete(); sb_q.delete(); pend_q.delete(); dvd_hq.delete(); dvs_hq.delete(); glog.delete();
    m_cnt = 0; mptr = 0; prev_pop = 0; prev_orph = 0; pop_now = 0; orph_now = 0;
    req_valid = '0; dout_tvalid = 1'b0;
    #1;
    check_zero("midreset");
    step(2);
    rst_n = 1'b1;
    dvd_tready = 1'b1; dvs_tready = 1'b1;
    step(1);
    for (int l = 0; l < N; l++) lane_q[l].push_back('{32'(50 + l), 32'(l + 1)});
    drain("post_drain");
    check("post_order", {32'(glog.size()), glog[0], glog[3]}, {32'd4, 32'd0, 32'd3});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
